// File: rtl/lte_dw_dfe_trans_sched_if.sv
// Control/status bundle of the DFE downlink transpose scheduler.
// Master drives enable/mode/sync, slave returns the timing strobes.
interface lte_dw_dfe_trans_sched_if;
    logic       i_enable;
    logic [1:0] i_mod_sel;
    logic       i_sync;
    logic       o_fram;
    logic       o_xant;
    logic [2:0] o_ant_idx;
    logic       o_locked;
    logic [1:0] o_state;
    logic       o_sync_err;
    logic [7:0] o_err_cnt;

    modport master (
        output i_enable, i_mod_sel, i_sync,
        input  o_fram, o_xant, o_ant_idx, o_locked,
        input  o_state, o_sync_err, o_err_cnt
    );

    modport slave (
        input  i_enable, i_mod_sel, i_sync,
        output o_fram, o_xant, o_ant_idx, o_locked,
        output o_state, o_sync_err, o_err_cnt
    );
endinterface

// File: rtl/lte_dw_dfe_trans_sched.sv
// Frame-sync locked slot/antenna scheduler for the x8 transpose datapath.
// Outputs are registered from the next-cycle counter values.
module lte_dw_dfe_trans_sched #(
    parameter int ANT_NUM     = 8,
    parameter int SYNC_PERIOD = 4915200,
    parameter int SYNC_TOL    = 2,
    parameter int MISS_MAX    = 3
) (
    input logic                      sys_clk_491p52,
    input logic                      sys_rst_491p52,
    lte_dw_dfe_trans_sched_if.slave  bus
);
    localparam int FW = $clog2(SYNC_PERIOD);
    localparam int AW = (ANT_NUM > 1) ? $clog2(ANT_NUM) : 1;
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [FW-1:0] F_LAST = FW'(SYNC_PERIOD - 1);
    localparam logic [FW-1:0] W_LO = FW'(SYNC_PERIOD - 1 - SYNC_TOL);
    localparam logic [AW-1:0] A_LAST = AW'(ANT_NUM - 1);
    localparam logic [MW-1:0] M_LAST = MW'(MISS_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [FW-1:0] frame_cnt, frame_d;
    logic [4:0]    slot_cnt, slot_d;
    logic [AW-1:0] ant, ant_d;
    logic [MW-1:0] miss, miss_d;
    logic [1:0]    mod_q, mod_d;
    logic [4:0]    last_q, last_d;
    logic          serr_d, err_inc;
    logic          in_win, f_end, s_end, run_d;

    function automatic logic [4:0] slot_last(input logic [1:0] m);
        return (m == 2'd1 || m == 2'd2) ? 5'd31 : 5'd15;
    endfunction

    assign last_q = slot_last(mod_q);
    assign last_d = slot_last(mod_d);
    assign in_win = frame_cnt >= W_LO;
    assign f_end  = frame_cnt == F_LAST;
    assign s_end  = slot_cnt == last_q;
    assign run_d  = state_d == RUN;
    assign bus.o_state = state;

    always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
        if (sys_rst_491p52) state <= IDLE;
        else                state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (!bus.i_enable) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE:     state_d = ARM;
                ARM, ERR: if (bus.i_sync) state_d = RUN;
                RUN: begin
                    if (!bus.i_sync && f_end && miss == M_LAST)
                        state_d = ERR;
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    // Any sync seen in RUN realigns; only in-window ones relatch the mode.
    always_comb begin
        frame_d = '0;
        slot_d  = '0;
        ant_d   = '0;
        miss_d  = miss;
        mod_d   = mod_q;
        serr_d  = 1'b0;
        err_inc = 1'b0;
        if (!bus.i_enable) begin
            miss_d = '0;
        end else begin
            unique case (state)
                IDLE: miss_d = '0;
                ARM, ERR: begin
                    if (bus.i_sync) begin
                        mod_d  = bus.i_mod_sel;
                        miss_d = '0;
                    end
                end
                RUN: begin
                    if (bus.i_sync) begin
                        if (in_win) begin
                            mod_d  = bus.i_mod_sel;
                            miss_d = '0;
                        end else begin
                            serr_d  = 1'b1;
                            err_inc = 1'b1;
                        end
                    end else begin
                        frame_d = f_end ? '0 : frame_cnt + FW'(1);
                        slot_d  = s_end ? '0 : slot_cnt + 5'd1;
                        ant_d   = ant;
                        if (s_end)
                            ant_d = (ant == A_LAST) ? '0 : ant + AW'(1);
                        if (f_end) begin
                            miss_d = miss + MW'(1);
                            if (miss == M_LAST) begin
                                err_inc = 1'b1;
                                miss_d  = '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
        if (sys_rst_491p52) begin
            frame_cnt      <= '0;
            slot_cnt       <= '0;
            ant            <= '0;
            miss           <= '0;
            mod_q          <= '0;
            bus.o_fram     <= 1'b0;
            bus.o_xant     <= 1'b0;
            bus.o_ant_idx  <= '0;
            bus.o_locked   <= 1'b0;
            bus.o_sync_err <= 1'b0;
            bus.o_err_cnt  <= '0;
        end else begin
            frame_cnt      <= frame_d;
            slot_cnt       <= slot_d;
            ant            <= ant_d;
            miss           <= miss_d;
            mod_q          <= mod_d;
            bus.o_fram     <= run_d && slot_d == 5'd0;
            bus.o_xant     <= run_d && slot_d == last_d;
            bus.o_ant_idx  <= run_d ? 3'(ant_d) : 3'd0;
            bus.o_locked   <= run_d;
            bus.o_sync_err <= serr_d;
            if (err_inc && bus.o_err_cnt != 8'hFF)
                bus.o_err_cnt <= bus.o_err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_lte_dw_dfe_trans_sched.sv
// Scoreboard bench: a cycle-indexed reference model predicts every output
// cycle from the last realign point; a negedge monitor compares.
module tb_lte_dw_dfe_trans_sched;
    localparam int P    = 256;
    localparam int TOL  = 2;
    localparam int MMAX = 3;
    localparam int A    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lte_dw_dfe_trans_sched_if bus();

    lte_dw_dfe_trans_sched #(
        .ANT_NUM(A), .SYNC_PERIOD(P),
        .SYNC_TOL(TOL), .MISS_MAX(MMAX)
    ) dut (
        .sys_clk_491p52(clk),
        .sys_rst_491p52(rst),
        .bus(bus)
    );

    typedef struct {
        int          cyc;
        logic [16:0] v;
    } exp_t;

    exp_t sb[$];
    int cyc_cnt = 0;
    int n_chk = 0;
    int n_pass = 0;

    // Reference model: state, realign cycle, slot length, misses, errors
    int m_state = 0;
    int m_anchor = 0;
    int m_len = 16;
    int m_miss = 0;
    int m_err = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [16:0] act_vec();
        return {bus.o_fram, bus.o_xant, bus.o_ant_idx, bus.o_locked,
                bus.o_state, bus.o_sync_err, bus.o_err_cnt};
    endfunction

    task automatic chk(input string name, input logic [16:0] act,
                       input logic [16:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            if (e.cyc != cyc_cnt)
                chk($sformatf("late_cyc%0d", e.cyc), 17'(cyc_cnt), 17'(e.cyc));
            else
                chk($sformatf("out_cyc%0d", e.cyc), act_vec(), e.v);
        end
    end

    function automatic int len_of(input logic [1:0] s);
        return (s == 2'd1 || s == 2'd2) ? 32 : 16;
    endfunction

    function automatic int fpos();
        return (cyc_cnt - m_anchor) % P;
    endfunction

    task automatic model(input logic en, input logic [1:0] sel,
                         input logic sync);
        int n, f, q;
        logic serr, run, fr, xa;
        logic [2:0] ai;
        n = cyc_cnt;
        f = (n - m_anchor) % P;
        serr = 1'b0;
        if (!en) begin
            m_state = 0;
            m_miss = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 || m_state == 3) begin
            if (sync) begin
                m_state = 2;
                m_anchor = n + 1;
                m_len = len_of(sel);
                m_miss = 0;
            end
        end else if (sync) begin
            if (f >= P - 1 - TOL) begin
                m_len = len_of(sel);
                m_miss = 0;
            end else begin
                serr = 1'b1;
                if (m_err < 255) m_err++;
            end
            m_anchor = n + 1;
        end else if (f == P - 1) begin
            m_miss++;
            if (m_miss == MMAX) begin
                m_state = 3;
                m_miss = 0;
                if (m_err < 255) m_err++;
            end
        end
        q = n + 1 - m_anchor;
        run = (m_state == 2);
        fr = run && (q % m_len == 0);
        xa = run && (q % m_len == m_len - 1);
        ai = run ? 3'((q / m_len) % A) : 3'd0;
        sb.push_back('{n + 1, {fr, xa, ai, run, 2'(m_state), serr, 8'(m_err)}});
    endtask

    task automatic step(input logic en, input logic [1:0] sel,
                        input logic sync);
        bus.i_enable = en;
        bus.i_mod_sel = sel;
        bus.i_sync = sync;
        model(en, sel, sync);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int at, input logic [1:0] sel);
        repeat (n) step(1'b1, sel, m_state == 2 && fpos() == at);
    endtask

    initial begin
        bus.i_enable = 1'b0;
        bus.i_mod_sel = 2'd0;
        bus.i_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", act_vec(), 17'd0);
        rst = 1'b0;

        // 20M lock, then 10M with a mid-frame mode change
        repeat (2) step(1'b0, 2'd3, 1'b0);
        repeat (6) step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd3, 1'b1);
        run(300, P - 1, 2'd3);
        run(300, P - 1, 2'd1);
        run(100, -1, 2'd3);
        run(400, P - 1, 2'd3);

        // early sync inside tolerance, then out-of-window syncs
        run(600, P - 1 - TOL, 2'd3);
        run(300, 100, 2'd2);
        run(300, P - 1, 2'd3);

        // sync lost for three frames, then relock from ERR
        run(3 * P + 20, -1, 2'd3);
        repeat (10) step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd0, 1'b1);
        run(60, P - 1, 2'd3);

        // disable mid-slot, re-enable, then async reset mid-slot
        repeat (3) step(1'b0, 2'd3, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd2, 1'b1);
        run(45, -1, 2'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", act_vec(), 17'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = 0;
        m_miss = 0;
        m_err = 0;
        m_len = 16;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic en, sy;
            logic [1:0] sel;
            en = ($urandom_range(0, 499) != 0);
            sel = 2'($urandom_range(0, 3));
            if (m_state == 2)
                sy = (fpos() >= P - 4) ? ($urandom_range(0, 1) == 0)
                                       : ($urandom_range(0, 299) == 0);
            else
                sy = ($urandom_range(0, 29) == 0);
            step(en, sel, sy);
        end

        // error counter saturation with sync on every other cycle
        step(1'b0, 2'd3, 1'b0);
        repeat (2) step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd3, 1'b1);
        for (int i = 0; i < 700; i++)
            step(1'b1, 2'd3, 1'(i % 2));
        run(20, P - 1, 2'd3);
        chk("err_sat", 17'(bus.o_err_cnt), 17'd255);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 17'(sb.size()), 17'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
